conv33_window_gen: RTL and testbench

Sliding-window generator feeding the 3x3 convolution input stage. Accepts a raster-order pixel stream of one IMG_W x IMG_H feature-map channel, holds two line buffers plus a 3x3 shift window, and emits each fully-populated 3x3 window (valid convolution, no padding) on a valid/ready handshake. Its window outputs connect one-to-one to the in_r_c inputs of the downstream 3x3 input buffer. A frame is bracketed by start/done.

---
 rtl/conv33_window_gen.sv | 158 +++++++++++++++
 tb/tb_conv33_window_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/conv33_window_gen.sv
// conv33_window_gen: raster pixel stream -> 3x3 valid-convolution windows.
// Define CONV33_WIN_CNT_EN to add the 16-bit win_cnt handshake counter port.
module conv33_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  done,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [DATA_WIDTH-1:0] pix_data,
    output logic                  valid_out,
    input  logic                  ready_in,
`ifdef CONV33_WIN_CNT_EN
    output logic [15:0]           win_cnt,
`endif
    output logic [DATA_WIDTH-1:0] win_0_0,
    output logic [DATA_WIDTH-1:0] win_0_1,
    output logic [DATA_WIDTH-1:0] win_0_2,
    output logic [DATA_WIDTH-1:0] win_1_0,
    output logic [DATA_WIDTH-1:0] win_1_1,
    output logic [DATA_WIDTH-1:0] win_1_2,
    output logic [DATA_WIDTH-1:0] win_2_0,
    output logic [DATA_WIDTH-1:0] win_2_1,
    output logic [DATA_WIDTH-1:0] win_2_2
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_last;
    logic          r_valid;

    logic [DATA_WIDTH-1:0] r_lb0 [IMG_W];
    logic [DATA_WIDTH-1:0] r_lb1 [IMG_W];
    logic [DATA_WIDTH-1:0] r_win [3][3];

    logic w_start_run;
    logic w_acc;
    logic w_hs;
    logic w_win_ok;
    logic w_last_pix;

    assign w_start_run = (r_state == S_IDLE) && start;
    assign pix_ready   = (r_state == S_RUN) && (!r_valid || ready_in)
                         && !r_last;
    assign w_acc       = pix_valid && pix_ready;
    assign w_hs        = r_valid && ready_in;
    assign w_win_ok    = (r_row >= RW'(2)) && (r_col >= CW'(2));
    assign w_last_pix  = (r_row == LAST_ROW) && (r_col == LAST_COL);

    assign done      = (r_state == S_DONE);
    assign valid_out = r_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_hs && r_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col   <= '0;
            r_row   <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_start_run) begin
            r_col   <= '0;
            r_row   <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_acc) begin
            r_valid <= w_win_ok;
            if (w_last_pix) r_last <= 1'b1;
            if (r_col == LAST_COL) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end else if (w_hs) begin
            r_valid <= 1'b0;
        end
    end

    // Line buffers hold the two previous rows; stale data is overwritten
    // before it can reach a valid window, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_lb1[r_col] <= r_lb0[r_col];
            r_lb0[r_col] <= pix_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    r_win[r][c] <= '0;
        end else if (w_acc) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= r_lb1[r_col];
            r_win[1][2] <= r_lb0[r_col];
            r_win[2][2] <= pix_data;
        end
    end

    assign win_0_0 = r_win[0][0];
    assign win_0_1 = r_win[0][1];
    assign win_0_2 = r_win[0][2];
    assign win_1_0 = r_win[1][0];
    assign win_1_1 = r_win[1][1];
    assign win_1_2 = r_win[1][2];
    assign win_2_0 = r_win[2][0];
    assign win_2_1 = r_win[2][1];
    assign win_2_2 = r_win[2][2];

`ifdef CONV33_WIN_CNT_EN
    logic [15:0] r_win_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             r_win_cnt <= '0;
        else if (w_start_run) r_win_cnt <= '0;
        else if (w_hs)        r_win_cnt <= r_win_cnt + 16'd1;
    end

    assign win_cnt = r_win_cnt;
`endif

endmodule

// File: tb/tb_conv33_window_gen.sv
// tb_conv33_window_gen: random/directed frames checked against a
// frame-array window model with an expected-window queue.
module tb_conv33_window_gen;

    localparam int DW   = 8;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int NWIN = (W - 2) * (H - 2);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          pix_valid = 1'b0;
    logic          ready_in = 1'b0;
    logic [DW-1:0] pix_data = '0;
    logic          done;
    logic          pix_ready;
    logic          valid_out;
    logic [DW-1:0] w00, w01, w02, w10, w11, w12, w20, w21, w22;
`ifdef CONV33_WIN_CNT_EN
    logic [15:0]   win_cnt;
`endif

    int n_chk = 0;
    int n_bad = 0;

    logic [DW-1:0] px [H][W];
    logic [71:0]   exp_q [$];

    always #5 clk = ~clk;

    conv33_window_gen #(
        .DATA_WIDTH (DW),
        .IMG_W      (W),
        .IMG_H      (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .done      (done),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .valid_out (valid_out),
        .ready_in  (ready_in),
`ifdef CONV33_WIN_CNT_EN
        .win_cnt   (win_cnt),
`endif
        .win_0_0   (w00),
        .win_0_1   (w01),
        .win_0_2   (w02),
        .win_1_0   (w10),
        .win_1_1   (w11),
        .win_1_2   (w12),
        .win_2_0   (w20),
        .win_2_1   (w21),
        .win_2_2   (w22)
    );

    task automatic chk(input string tag, input logic [71:0] got,
                       input logic [71:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] win_now();
        return {w00, w01, w02, w10, w11, w12, w20, w21, w22};
    endfunction

    // Expected windows: every 3x3 block fully inside the frame, raster order.
    task automatic build_model(input int pat);
        exp_q.delete();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                px[r][c] = (pat == 0) ? DW'(r * W + c) : DW'($urandom);
        for (int r = 2; r < H; r++)
            for (int c = 2; c < W; c++)
                exp_q.push_back({px[r-2][c-2], px[r-2][c-1], px[r-2][c],
                                 px[r-1][c-2], px[r-1][c-1], px[r-1][c],
                                 px[r][c-2],   px[r][c-1],   px[r][c]});
    endtask

    // vmode: 0 always valid, 1 every other cycle, 2 random.
    // rmode: 0 always ready, 1 five-cycle stall on first window, 2 random.
    task automatic run_frame(input int pat, input int vmode, input int rmode,
                             input int abort_at, input bit poke_start);
        int n_acc = 0;
        int n_hs = 0;
        int pend = 0;
        int stall = 0;
        bit seen_first = 1'b0;
        bit prev_final = 1'b0;
        bit prev_hold = 1'b0;
        bit finished = 1'b0;
        bit hs, acc;
        logic [71:0] prev_win = '0;
        logic [71:0] e;

        build_model(pat);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (abort_at > 0 && n_acc == abort_at) begin
                rst = 1'b0;
                pix_valid = 1'b0;
                #1;
                chk("rst_ctl", {done, pix_ready, valid_out}, 0);
                chk("rst_win", win_now(), 0);
                @(negedge clk) rst = 1'b1;
                return;
            end
            start = poke_start && (cyc == 6);
            pix_valid = (n_acc < NPIX) && ((vmode == 0)
                        || (vmode == 1 && cyc % 2 == 0)
                        || (vmode == 2 && $urandom_range(0, 1) == 1));
            pix_data = (n_acc < NPIX) ? px[n_acc / W][n_acc % W]
                                      : DW'($urandom);
            ready_in = (rmode == 0) ? 1'b1 :
                       (rmode == 1) ? (stall == 0) :
                       ($urandom_range(0, 2) != 0);
            if (stall > 0) stall--;
            #1;
            chk("done", done, prev_final);
`ifdef CONV33_WIN_CNT_EN
            if (cyc == 0) chk("cnt_clr", win_cnt, 0);
`endif
            if (prev_final) begin
                finished = 1'b1;
                chk("done_pr", pix_ready, 0);
                chk("done_vo", valid_out, 0);
`ifdef CONV33_WIN_CNT_EN
                chk("cnt_done", win_cnt, NWIN);
`endif
                @(negedge clk);
                start = 1'b0;
                #1;
                chk("done_1cyc", done, 0);
                chk("idle_pr", pix_ready, 0);
            end else begin
                chk("vo", valid_out, pend > 0);
                chk("pr", pix_ready,
                    (n_acc < NPIX) && !(valid_out && !ready_in));
                if (prev_hold) chk("hold", win_now(), prev_win);
                hs  = valid_out && ready_in;
                acc = pix_valid && pix_ready;
                if (hs) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_win", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("win", win_now(), e);
                    end
                    if (pat == 0 && n_hs == 0) chk("first_w22", w22, 10);
                    n_hs++;
                    pend--;
                end
                prev_final = hs && (n_hs == NWIN);
                if (acc) begin
                    if (n_acc / W >= 2 && n_acc % W >= 2) begin
                        pend++;
                        if (rmode == 1 && !seen_first) begin
                            seen_first = 1'b1;
                            stall = 5;
                        end
                    end
                    n_acc++;
                end
                prev_hold = valid_out && !ready_in;
                prev_win  = win_now();
            end
        end
        if (!finished) chk("timeout", 0, 1);
        start = 1'b0;
        pix_valid = 1'b0;
        ready_in = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctl", {done, pix_ready, valid_out}, 0);
        chk("reset_win", win_now(), 0);
        @(negedge clk) rst = 1'b1;
        run_frame(0, 0, 0, 0, 1'b0);
        run_frame(0, 0, 1, 0, 1'b0);
        run_frame(0, 1, 0, 0, 1'b0);
        run_frame(0, 0, 0, 7, 1'b0);
        run_frame(0, 0, 0, 0, 1'b0);
        run_frame(0, 0, 0, 0, 1'b1);
        for (int i = 0; i < 6; i++) run_frame(1, 2, 2, 0, 1'b0);
        run_frame(1, 2, 2, 5, 1'b0);
        run_frame(1, 1, 1, 0, 1'b0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
